// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED bank controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        PASS  = 2'd0,
        ROT   = 2'd1,
        CNT   = 2'd2,
        BLINK = 2'd3
    } mode_e;

    // Button bit positions
    localparam int BTN_MODE  = 0;
    localparam int BTN_DIR   = 1;
    localparam int BTN_PAUSE = 2;
    localparam int BTN_CLR   = 3;
    localparam int BTN_STEP  = 4;

    localparam int PWM_W = 4;

    // Mode sequence PASS->ROT->CNT->BLINK->PASS relies on 2-bit wraparound
    function automatic mode_e next_mode(input mode_e m);
        return mode_e'(m + 2'd1);
    endfunction

endpackage

// File: rtl/led_ctrl_btn_debounce.sv
// Per-button synchroniser, debounce counter and one-cycle press pulse.
// Latency: raw edge to o_press is DB_CYC+2 cycles (sync 2 + DB_CYC stable observations).
// Backpressure: none; glitches shorter than DB_CYC cycles are dropped.
//
// Ports: clk, rst (sync active-low), i_btn (raw async), o_press (registered pulse).
module btn_debounce #(
    parameter int DB_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = $clog2(DB_CYC + 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_db;
    logic          r_arm;
    logic          r_press;
    logic [1:0]    r_warm;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_db    <= 1'b0;
            r_arm   <= 1'b0;
            r_press <= 1'b0;
            r_warm  <= 2'b00;
            r_cnt   <= '0;
        end else begin
            r_s1    <= i_btn;
            r_s2    <= r_s1;
            r_warm  <= {r_warm[0], 1'b1};
            r_press <= 1'b0;

            // The synchroniser holds reset zeros for two cycles, so a button
            // only arms once a genuinely released level has been seen. A button
            // held through reset therefore debounces high silently and needs a
            // release before its next press pulses.
            if (r_warm[1] && !r_s2 && !r_db)
                r_arm <= 1'b1;

            if (r_s2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DB_CYC - 1)) begin
                r_cnt   <= '0;
                r_db    <= r_s2;
                r_press <= r_s2 & r_arm;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/led_ctrl.sv
// Board LED controller: switch passthrough, rotate, count and blink display modes.
// Latency: switch change to ledr 3 cycles; button press to ledr DB_CYC+4 cycles.
// Backpressure: none; all inputs sampled every cycle.
//
// Ports: clk, rst (sync active-low), btn[BTN_W] raw buttons, sw[SW_W] raw
// switches, ledr[LED_W] registered LED drive.
// Optional: define LED_CTRL_PWM_EN to dim ROT/CNT/BLINK with a duty from the
// top four switches.
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int LED_W  = 16,
    parameter int SW_W   = 8,
    parameter int BTN_W  = 5,
    parameter int DIV    = 5000000,
    parameter int DB_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BTN_W-1:0] btn,
    input  logic [SW_W-1:0]  sw,
    output logic [LED_W-1:0] ledr
);

    localparam int PW = $clog2(DIV);

    logic [SW_W-1:0]  r_sw_s1;
    logic [SW_W-1:0]  r_sw_s;
    logic [BTN_W-1:0] w_press;
    logic [PW-1:0]    r_presc;
    mode_e            r_mode;
    logic             r_dir;
    logic             r_paused;
    logic             r_phase;
    logic [LED_W-1:0] r_rot;
    logic [LED_W-1:0] r_cnt;
    logic [LED_W-1:0] r_ledr;
    logic [LED_W-1:0] w_pass;
    logic [LED_W-1:0] w_ledr_nxt;
    logic [LED_W-1:0] w_ledr_out;
    logic             w_tick;
    logic             w_adv;

    for (genvar g = 0; g < BTN_W; g++) begin : g_btn
        btn_debounce #(.DB_CYC(DB_CYC)) u_db (
            .clk     (clk),
            .rst     (rst),
            .i_btn   (btn[g]),
            .o_press (w_press[g])
        );
    end

    assign w_tick = (r_presc == PW'(DIV - 1));
    // Step only counts while paused; otherwise the free-running tick drives.
    assign w_adv  = (w_tick & ~r_paused) | (w_press[BTN_STEP] & r_paused);

    always_comb begin
        w_pass             = '0;
        w_pass[SW_W-1:0]   = r_sw_s;
        w_pass[SW_W]       = ^r_sw_s;
        w_ledr_nxt         = '0;
        case (r_mode)
            PASS:    w_ledr_nxt = w_pass;
            ROT:     w_ledr_nxt = r_rot;
            CNT:     w_ledr_nxt = r_cnt;
            BLINK:   w_ledr_nxt = r_phase ? LED_W'(r_sw_s) : '0;
            default: w_ledr_nxt = '0;
        endcase
    end

`ifdef LED_CTRL_PWM_EN
    logic [PWM_W-1:0] r_pwm;
    logic [PWM_W-1:0] w_duty;
    logic             w_gate;

    assign w_duty = r_sw_s[SW_W-1 -: PWM_W];
    // Full-scale duty must stay lit every cycle, not 15 of 16.
    assign w_gate = (w_duty == '1) | (r_pwm < w_duty);

    always_ff @(posedge clk) begin
        if (!rst) r_pwm <= '0;
        else      r_pwm <= r_pwm + PWM_W'(1);
    end

    assign w_ledr_out = ((r_mode == PASS) || w_gate) ? w_ledr_nxt : '0;
`else
    assign w_ledr_out = w_ledr_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sw_s1  <= '0;
            r_sw_s   <= '0;
            r_presc  <= '0;
            r_mode   <= PASS;
            r_dir    <= 1'b0;
            r_paused <= 1'b0;
            r_phase  <= 1'b0;
            r_rot    <= LED_W'(1);
            r_cnt    <= '0;
            r_ledr   <= '0;
        end else begin
            r_sw_s1 <= sw;
            r_sw_s  <= r_sw_s1;
            r_presc <= w_tick ? '0 : r_presc + PW'(1);

            if (w_press[BTN_MODE])  r_mode   <= next_mode(r_mode);
            if (w_press[BTN_DIR])   r_dir    <= ~r_dir;
            if (w_press[BTN_PAUSE]) r_paused <= ~r_paused;

            // Clear wins over a coincident advance; the advance sees the
            // pre-press dir and paused values.
            if (w_press[BTN_CLR]) begin
                r_rot   <= LED_W'(1);
                r_cnt   <= '0;
                r_phase <= 1'b0;
                r_presc <= '0;
            end else if (w_adv) begin
                r_rot   <= r_dir ? {r_rot[0], r_rot[LED_W-1:1]}
                                 : {r_rot[LED_W-2:0], r_rot[LED_W-1]};
                r_cnt   <= r_cnt + LED_W'(1);
                r_phase <= ~r_phase;
            end

            r_ledr <= w_ledr_out;
        end
    end

    assign ledr = r_ledr;

endmodule
